// File: rtl/uart_tx.sv
// uart_tx: oversampled UART transmitter with configurable data length, parity
// and stop bits. A request is accepted only while idle and clear-to-send; the
// frame is then shifted out on tx, one bit per OVERSAMPLE tick pulses.
module uart_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       cts_n,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(OVERSAMPLE);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST_TICK = cnt_t'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state, state_next;
  cnt_t       tick_cnt, tick_cnt_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic       stop_cnt, stop_cnt_next;
  logic [7:0] data_q, data_q_next;
  logic [1:0] len_q, len_q_next;
  logic       stop_q, stop_q_next;
  logic       pe_q, pe_q_next;
  logic       pt_q, pt_q_next;
  logic       tx_next, tx_busy_next, tx_done_next;

  logic       bit_end;
  logic       last_data;
  logic [7:0] data_mask;
  logic       parity_bit;

  assign tx_ready   = (state == IDLE) && !cts_n;
  assign bit_end    = tick && (tick_cnt == LAST_TICK);
  // Index of the final data bit is N-1 = 4 + encoded length.
  assign last_data  = (bit_cnt == (3'd4 + {1'b0, len_q}));
  // Only the N transmitted bits take part in the parity.
  assign data_mask  = ~(8'hFF << (4'd5 + {2'b00, len_q}));
  assign parity_bit = (^(data_q & data_mask)) ^ pt_q;

  // Next-state and next-output computation for every register.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_cnt_next  = bit_cnt;
    stop_cnt_next = stop_cnt;
    data_q_next   = data_q;
    len_q_next    = len_q;
    stop_q_next   = stop_q;
    pe_q_next     = pe_q;
    pt_q_next     = pt_q;
    tx_next       = tx;
    tx_busy_next  = tx_busy;
    tx_done_next  = 1'b0;

    if (state != IDLE && tick) begin
      tick_cnt_next = bit_end ? '0 : cnt_t'(tick_cnt + 1'b1);
    end

    case (state)
      IDLE: begin
        tick_cnt_next = '0;
        if (tx_valid && tx_ready) begin
          data_q_next  = tx_data;
          len_q_next   = data_bit_num;
          stop_q_next  = stop_bit_num;
          pe_q_next    = parity_en;
          pt_q_next    = parity_type;
          state_next   = START;
          tx_next      = 1'b0;
          tx_busy_next = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_cnt_next = '0;
          tx_next      = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (last_data) begin
            if (pe_q) begin
              state_next = PARITY;
              tx_next    = parity_bit;
            end else begin
              state_next    = STOP;
              stop_cnt_next = 1'b0;
              tx_next       = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            tx_next      = data_q[bit_cnt + 3'd1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next    = STOP;
          stop_cnt_next = 1'b0;
          tx_next       = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q && !stop_cnt) begin
            stop_cnt_next = 1'b1;
          end else begin
            state_next   = IDLE;
            tx_done_next = 1'b1;
            tx_busy_next = 1'b0;
            tx_next      = 1'b1;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        tx_next      = 1'b1;
        tx_busy_next = 1'b0;
      end
    endcase
  end

  // State register with asynchronous reset to an idle, high line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      // NOTE: the latched frame fields are reset too, so a reset mid-frame
      // leaves no stale payload or configuration behind.
      data_q   <= '0;
      len_q    <= '0;
      stop_q   <= 1'b0;
      pe_q     <= 1'b0;
      pt_q     <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register updates from
      // the same pre-edge values; the comb block above uses blocking ones.
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_cnt  <= bit_cnt_next;
      stop_cnt <= stop_cnt_next;
      data_q   <= data_q_next;
      len_q    <= len_q_next;
      stop_q   <= stop_q_next;
      pe_q     <= pe_q_next;
      pt_q     <= pt_q_next;
      tx       <= tx_next;
      tx_busy  <= tx_busy_next;
      tx_done  <= tx_done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized frames checked against a bit-list model
// of the serial frame; tick pulses are driven with random spacing.
module tb_uart_tx;

  localparam int OS = 16;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       cts_n;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int total = 0;
  int bad   = 0;

  // Expected line levels of one frame, one entry per bit time.
  logic exp_bits[$];

  uart_tx #(.OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .cts_n        (cts_n),
    .tx_ready     (tx_ready),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Frame model: start 0, N data bits LSB first, optional parity, 1 or 2 stops.
  function automatic void build_frame(input logic [7:0] d, input logic [1:0] len,
                                      input logic stop, input logic pe, input logic pt);
    int n;
    int ones;
    n    = 5 + int'(len);
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) exp_bits.push_back(logic'(ones % 2) ^ pt);
    exp_bits.push_back(1'b1);
    if (stop) exp_bits.push_back(1'b1);
  endfunction

  task automatic scramble();
    tx_data      = 8'($urandom);
    data_bit_num = 2'($urandom);
    stop_bit_num = 1'($urandom);
    parity_en    = 1'($urandom);
    parity_type  = 1'($urandom);
    cts_n        = 1'($urandom);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, "_tx"}, tx, 1'b1);
    check({tag, "_busy"}, tx_busy, 1'b0);
    check({tag, "_done"}, tx_done, 1'b0);
  endtask

  // Drives one frame request and checks the line for every tick of every bit.
  // Called at #1 after a posedge. abort_bit >= 0 pulls reset mid-bit instead.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] len, input logic stop,
                           input logic pe, input logic pt, input bit hold, input int abort_bit);
    build_frame(d, len, stop, pe, pt);
    tx_data      = d;
    data_bit_num = len;
    stop_bit_num = stop;
    parity_en    = pe;
    parity_type  = pt;
    cts_n        = 1'b0;
    tx_valid     = 1'b1;
    #1;
    check("ready_before", tx_ready, 1'b1);
    tick = 1'($urandom);
    @(posedge clk); #1;
    tick = 1'b0;
    if (!hold) tx_valid = 1'b0;
    scramble();
    cts_n = 1'b1;
    for (int b = 0; b < exp_bits.size(); b++) begin
      for (int k = 0; k < OS; k++) begin
        if (b == abort_bit && k == OS / 2) begin
          rst_n = 1'b0;
          #1;
          check("rst_tx", tx, 1'b1);
          check("rst_busy", tx_busy, 1'b0);
          check("rst_done", tx_done, 1'b0);
          return;
        end
        check($sformatf("bit%0d_t%0d_tx", b, k), tx, exp_bits[b]);
        check($sformatf("bit%0d_t%0d_busy", b, k), tx_busy, 1'b1);
        check($sformatf("bit%0d_t%0d_done", b, k), tx_done, 1'b0);
        if ($urandom_range(0, 3) == 0) begin
          scramble();
          if (!hold) tx_valid = 1'($urandom);
        end
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          check($sformatf("bit%0d_gap_tx", b), tx, exp_bits[b]);
        end
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
      end
    end
    check("end_done", tx_done, 1'b1);
    check("end_busy", tx_busy, 1'b0);
    check("end_tx", tx, 1'b1);
    check("end_ready", tx_ready, ~cts_n);
    if (!hold) tx_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    tick         = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    data_bit_num = 2'b00;
    stop_bit_num = 1'b0;
    parity_en    = 1'b0;
    parity_type  = 1'b0;
    cts_n        = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_done", tx_done, 1'b0);
    check("reset_ready", tx_ready, 1'b1);
    rst_n = 1'b1;

    // 8N1 0x55, accepted on the first edge after reset release.
    run_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle_check("after_8n1");

    // Ticks while idle must not disturb the next frame.
    repeat (5) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
    end
    check("idle_tick_tx", tx, 1'b1);

    // 7E2 0xB3 and 5O1 0xFF.
    run_frame(8'hB3, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    idle_check("after_7e2");
    run_frame(8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    idle_check("after_5o1");

    // Clear-to-send holds off a pending request.
    cts_n    = 1'b1;
    tx_valid = 1'b1;
    #1;
    check("cts_ready", tx_ready, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("cts_hold_tx", tx, 1'b1);
      check("cts_hold_busy", tx_busy, 1'b0);
    end
    run_frame(8'hA7, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    idle_check("after_cts");

    // Reset during data bit 3 (frame bit index 4), then a clean frame.
    run_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    @(posedge clk); #1;
    check("rst_hold_tx", tx, 1'b1);
    check("rst_hold_busy", tx_busy, 1'b0);
    rst_n = 1'b1;
    run_frame(8'hC5, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    idle_check("after_rst");

    // Three contiguous frames with tx_valid held high.
    run_frame(8'h12, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    run_frame(8'hE9, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    run_frame(8'h6B, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    tx_valid = 1'b0;
    idle_check("after_b2b");
    idle_check("after_b2b2");

    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      run_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'b0, -1);
      idle_check($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
